// File: rtl/drec_pkg.sv
// Shared types and defaults for the recorder SDRAM arbitration logic.
//   ADDR_W_DEF / DATA_W_DEF : default SDRAM word address / data widths
//   state_t                 : host-port arbiter FSM states
//   grant_t                 : two-way grant encoding (W = record, R = playback)
package drec_pkg;

   localparam int unsigned ADDR_W_DEF = 24;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      RD_ISSUE,
      WR_WAIT,
      RD_WAIT
   } state_t;

   typedef enum logic {
      GNT_W = 1'b0,
      GNT_R = 1'b1
   } grant_t;

endpackage

// File: rtl/drec_rr_pick.sv
// Combinational 2-way round-robin pick with a write-urgent override.
//   i_wr_req, i_rd_req : pending requests
//   i_wr_urgent        : W wins any contention
//   i_last_grant       : requester granted most recently
//   o_valid            : at least one request pending
//   o_grant            : selected requester (meaningful when o_valid)
module drec_rr_pick
   import drec_pkg::*;
(
   input  logic   i_wr_req,
   input  logic   i_rd_req,
   input  logic   i_wr_urgent,
   input  grant_t i_last_grant,
   output logic   o_valid,
   output grant_t o_grant
);

   always_comb begin
      o_valid = i_wr_req | i_rd_req;
      o_grant = GNT_W;
      if (i_wr_req && i_rd_req) begin
         o_grant = (i_wr_urgent || (i_last_grant == GNT_R)) ? GNT_W : GNT_R;
      end else if (i_rd_req) begin
         o_grant = GNT_R;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller host port between the record path (W, writes)
// and the playback path (R, reads). One command outstanding at a time, with a
// per-command timeout guarding against a hung controller.
//   wr_req/wr_urgent/wr_req_addr/wr_req_data -> wr_ack    : write requester
//   rd_req/rd_req_addr -> rd_ack, rd_resp_data/valid      : read requester
//   ctl_wr_* / ctl_rd_* / ctl_busy                        : controller side
//   timeout_err                                           : sticky abort flag
module sdram_port_arbiter
   import drec_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned TIMEOUT_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req,
   input  logic              wr_urgent,
   input  logic [ADDR_W-1:0] wr_req_addr,
   input  logic [DATA_W-1:0] wr_req_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_req_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_resp_data,
   output logic              rd_resp_valid,
   output logic [ADDR_W-1:0] ctl_wr_addr,
   output logic [DATA_W-1:0] ctl_wr_data,
   output logic              ctl_wr_enable,
   output logic [ADDR_W-1:0] ctl_rd_addr,
   output logic              ctl_rd_enable,
   input  logic [DATA_W-1:0] ctl_rd_data,
   input  logic              ctl_rd_ready,
   input  logic              ctl_busy,
   output logic              timeout_err
);

   state_t                r_state;
   state_t                w_next;
   grant_t                r_last_grant;
   logic [TIMEOUT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0]     r_wr_addr;
   logic [DATA_W-1:0]     r_wr_data;
   logic [ADDR_W-1:0]     r_rd_addr;
   logic [DATA_W-1:0]     r_rd_data;
   logic                  r_resp_valid;
   logic                  r_timeout_err;

   logic                  w_pick_valid;
   grant_t                w_pick_grant;
   logic                  w_wr_issue;
   logic                  w_rd_issue;
   logic                  w_rd_done;
   logic                  w_wr_to;
   logic                  w_rd_to;
   logic                  w_cnt_full;
   logic                  w_grant;

   drec_rr_pick u_pick (
      .i_wr_req     (wr_req),
      .i_rd_req     (rd_req),
      .i_wr_urgent  (wr_urgent),
      .i_last_grant (r_last_grant),
      .o_valid      (w_pick_valid),
      .o_grant      (w_pick_grant)
   );

   assign w_cnt_full = (r_cnt == '1);
   assign w_grant    = (r_state == IDLE) && w_pick_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Wait states: r_cnt counts cycles spent in *_WAIT (0 on the first one).
   // Completion is checked before the timeout, so a response arriving in the
   // last counted cycle still wins over the abort.
   always_comb begin
      w_next     = r_state;
      w_wr_issue = 1'b0;
      w_rd_issue = 1'b0;
      w_rd_done  = 1'b0;
      w_wr_to    = 1'b0;
      w_rd_to    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_next = (w_pick_grant == GNT_W) ? WR_ISSUE : RD_ISSUE;
            end
         end
         WR_ISSUE: begin
            if (!ctl_busy) begin
               w_wr_issue = 1'b1;
               w_next     = WR_WAIT;
            end
         end
         RD_ISSUE: begin
            if (!ctl_busy) begin
               w_rd_issue = 1'b1;
               w_next     = RD_WAIT;
            end
         end
         WR_WAIT: begin
            // First wait cycle ignores busy: the controller raises it one
            // cycle after the enable strobe.
            if ((r_cnt != '0) && !ctl_busy) begin
               w_next = IDLE;
            end else if (w_cnt_full) begin
               w_wr_to = 1'b1;
               w_next  = IDLE;
            end
         end
         RD_WAIT: begin
            if (ctl_rd_ready) begin
               w_rd_done = 1'b1;
               w_next    = IDLE;
            end else if (w_cnt_full) begin
               w_rd_to = 1'b1;
               w_next  = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant  <= GNT_R;
         r_cnt         <= '0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_rd_addr     <= '0;
         r_rd_data     <= '0;
         r_resp_valid  <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_grant) begin
            r_last_grant <= w_pick_grant;
            if (w_pick_grant == GNT_W) begin
               r_wr_addr <= wr_req_addr;
               r_wr_data <= wr_req_data;
            end else begin
               r_rd_addr <= rd_req_addr;
            end
         end

         if (w_wr_issue || w_rd_issue) begin
            r_cnt <= '0;
         end else if ((r_state == WR_WAIT) || (r_state == RD_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
         end

         // A timed-out read still returns a (zero) sample so playback never stalls.
         r_resp_valid <= w_rd_done | w_rd_to;
         if (w_rd_done) begin
            r_rd_data <= ctl_rd_data;
         end else if (w_rd_to) begin
            r_rd_data <= '0;
         end

         if (w_wr_to || w_rd_to) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign wr_ack        = w_wr_issue;
   assign ctl_wr_enable = w_wr_issue;
   assign rd_ack        = w_rd_issue;
   assign ctl_rd_enable = w_rd_issue;
   assign ctl_wr_addr   = r_wr_addr;
   assign ctl_wr_data   = r_wr_data;
   assign ctl_rd_addr   = r_rd_addr;
   assign rd_resp_data  = r_rd_data;
   assign rd_resp_valid = r_resp_valid;
   assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (TIMEOUT_W = 4).
// A small controller model answers enables: busy for wr_busy_len cycles after
// a write enable, ctl_rd_ready rd_lat cycles after a read enable (0 = never).
module tb_sdram_port_arbiter;
   import drec_pkg::*;

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_req, wr_urgent, rd_req;
   logic [AW-1:0] wr_req_addr, rd_req_addr;
   logic [DW-1:0] wr_req_data;
   logic          wr_ack, rd_ack, rd_resp_valid;
   logic [DW-1:0] rd_resp_data;
   logic [AW-1:0] ctl_wr_addr, ctl_rd_addr;
   logic [DW-1:0] ctl_wr_data, ctl_rd_data;
   logic          ctl_wr_enable, ctl_rd_enable;
   logic          ctl_rd_ready, ctl_busy;
   logic          timeout_err;

   sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_req        (wr_req),
      .wr_urgent     (wr_urgent),
      .wr_req_addr   (wr_req_addr),
      .wr_req_data   (wr_req_data),
      .wr_ack        (wr_ack),
      .rd_req        (rd_req),
      .rd_req_addr   (rd_req_addr),
      .rd_ack        (rd_ack),
      .rd_resp_data  (rd_resp_data),
      .rd_resp_valid (rd_resp_valid),
      .ctl_wr_addr   (ctl_wr_addr),
      .ctl_wr_data   (ctl_wr_data),
      .ctl_wr_enable (ctl_wr_enable),
      .ctl_rd_addr   (ctl_rd_addr),
      .ctl_rd_enable (ctl_rd_enable),
      .ctl_rd_data   (ctl_rd_data),
      .ctl_rd_ready  (ctl_rd_ready),
      .ctl_busy      (ctl_busy),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [85:0] outs;
   assign outs = {wr_ack, rd_ack, rd_resp_valid, rd_resp_data, ctl_wr_addr, ctl_wr_data,
                  ctl_wr_enable, ctl_rd_addr, ctl_rd_enable, timeout_err};

   // Controller model
   int          busy_left = 0, rd_left = 0, wr_busy_len = 3, rd_lat = 4;
   logic [DW-1:0] rd_val = '0;
   logic        saw_w = 1'b0, saw_r = 1'b0;
   logic        model_busy = 1'b0, model_ready = 1'b0, hold_busy = 1'b0, man_ready = 1'b0;
   assign ctl_busy     = model_busy | hold_busy;
   assign ctl_rd_ready = model_ready | man_ready;

   always @(negedge clk) begin
      saw_w = ctl_wr_enable;
      saw_r = ctl_rd_enable;
   end

   initial ctl_rd_data = 16'hDEAD;
   always @(posedge clk) begin
      #1;
      if (saw_w) busy_left = wr_busy_len;
      if (saw_r) rd_left = rd_lat;
      model_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      model_ready = 1'b0;
      ctl_rd_data = 16'hDEAD;
      if (rd_left > 0) begin
         rd_left--;
         if (rd_left == 0) begin
            model_ready = 1'b1;
            ctl_rd_data = rd_val;
         end
      end
   end

   // Monitor
   int     n_wack = 0, n_rack = 0, n_resp = 0, n_dbl = 0;
   logic   p_wack = 1'b0, p_rack = 1'b0;
   grant_t gq[$];
   always @(negedge clk) begin
      if (wr_ack) begin n_wack++; gq.push_back(GNT_W); end
      if (rd_ack) begin n_rack++; gq.push_back(GNT_R); end
      if (rd_resp_valid) n_resp++;
      if ((wr_ack && p_wack) || (rd_ack && p_rack) || (wr_ack && rd_ack)) n_dbl++;
      p_wack = wr_ack;
      p_rack = rd_ack;
   end

   int n_checks = 0, n_errs = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
      #1;
   endtask

   // sel: 0 wr_ack, 1 rd_ack, 2 rd_resp_valid; c = cycle seen or -1 on expiry
   task automatic wait_ev(input int sel, input int lim, output int c);
      c = -1;
      for (int i = 0; i < lim; i++) begin
         smp();
         if ((sel == 0 && wr_ack) || (sel == 1 && rd_ack) || (sel == 2 && rd_resp_valid)) begin
            c = cyc;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c, k, e, r, a, b, bw, br, bresp;
      logic [1:0] g;
      rst_n = 1'b0;
      wr_req = 1'b0; wr_urgent = 1'b0; rd_req = 1'b0;
      wr_req_addr = '0; wr_req_data = '0; rd_req_addr = '0;
      repeat (3) smp();
      check("rst_outs", outs, '0);
      rst_n = 1'b1;

      // 1: single write
      drv();
      wr_req = 1'b1; wr_req_addr = 24'h000010; wr_req_data = 16'hBEEF; k = cyc;
      smp();
      check("t1_no_early_ack", wr_ack, 1'b0);
      wait_ev(0, 20, c);
      check("t1_ack_cycle", c, k + 1);
      check("t1_wr_en", ctl_wr_enable, 1'b1);
      check("t1_wr_addr", ctl_wr_addr, 24'h000010);
      check("t1_wr_data", ctl_wr_data, 16'hBEEF);
      check("t1_no_rd", {rd_ack, ctl_rd_enable}, 2'b00);
      e = c;
      drv(); wr_req = 1'b0;
      smp();
      check("t1_ack_pulse", {wr_ack, ctl_wr_enable}, 2'b00);

      // 2: read raised during WR_WAIT stays pending until the write finishes
      drv(); rd_val = 16'h1234; rd_req = 1'b1; rd_req_addr = 24'h000020;
      wait_ev(1, 20, c);
      check("t2_ack_cycle", c, e + 6);
      check("t2_rd_en", ctl_rd_enable, 1'b1);
      check("t2_rd_addr", ctl_rd_addr, 24'h000020);
      check("t2_wr_addr_hold", ctl_wr_addr, 24'h000010);
      r = c;
      drv(); rd_req = 1'b0;
      wait_ev(2, 20, c);
      check("t2_resp_cycle", c, r + 5);
      check("t2_resp_data", rd_resp_data, 16'h1234);
      smp();
      check("t2_resp_pulse", rd_resp_valid, 1'b0);
      check("t12_wacks", n_wack, 1);
      check("t12_racks", n_rack, 1);

      // 3: continuous contention alternates W,R,W,R
      drv();
      gq.delete(); bw = n_wack; br = n_rack; bresp = n_resp;
      rd_val = 16'h5A5A;
      wr_req = 1'b1; wr_req_addr = 24'h000100; wr_req_data = 16'h0101;
      rd_req = 1'b1; rd_req_addr = 24'h000200;
      for (int i = 0; i < 300 && gq.size() < 4; i++) smp();
      drv(); wr_req = 1'b0; rd_req = 1'b0;
      repeat (20) smp();
      check("t3_grant_count", gq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         g = (i < gq.size()) ? {1'b0, gq[i]} : 2'b11;
         check($sformatf("t3_grant%0d", i), g, (i % 2));
      end
      check("t3_wacks", n_wack - bw, 2);
      check("t3_racks", n_rack - br, 2);
      check("t3_resps", n_resp - bresp, 2);
      check("t3_resp_data", rd_resp_data, 16'h5A5A);

      // 4: urgent override with last_grant = W
      drv(); wr_req = 1'b1; wr_req_addr = 24'h000300;
      wait_ev(0, 20, c);
      drv(); wr_req = 1'b0;
      repeat (10) smp();
      drv();
      gq.delete();
      wr_urgent = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      for (int i = 0; i < 50 && gq.size() < 1; i++) smp();
      drv(); wr_urgent = 1'b0;
      for (int i = 0; i < 50 && gq.size() < 2; i++) smp();
      drv(); wr_req = 1'b0; rd_req = 1'b0;
      repeat (20) smp();
      g = (gq.size() > 0) ? {1'b0, gq[0]} : 2'b11;
      check("t4_urgent_w", g, 2'b00);
      g = (gq.size() > 1) ? {1'b0, gq[1]} : 2'b11;
      check("t4_then_r", g, 2'b01);

      // 5a: busy controller blocks issue
      drv();
      hold_busy = 1'b1; b = n_wack;
      wr_req = 1'b1; wr_req_addr = 24'hABCDEF; wr_req_data = 16'h0F0F;
      repeat (6) smp();
      check("t5_no_ack_busy", n_wack - b, 0);
      check("t5_no_en_busy", ctl_wr_enable, 1'b0);
      drv(); hold_busy = 1'b0;
      smp();
      check("t5_ack_on_release", {wr_ack, ctl_wr_enable}, 2'b11);
      check("t5_wr_addr", ctl_wr_addr, 24'hABCDEF);
      drv(); wr_req = 1'b0;
      repeat (10) smp();

      // 5b: read never answered -> timeout after the wait budget
      drv(); rd_lat = 0;
      drv(); rd_req = 1'b1; rd_req_addr = 24'h000400;
      wait_ev(1, 20, a);
      check("t5_err_clean", timeout_err, 1'b0);
      drv(); rd_req = 1'b0;
      wait_ev(2, 40, c);
      check("t5_to_cycle", c, a + 17);
      check("t5_to_err", timeout_err, 1'b1);
      check("t5_to_data", rd_resp_data, 16'h0000);
      repeat (5) smp();
      check("t5_err_sticky", timeout_err, 1'b1);

      // 6: reset in RD_WAIT, then a stale ready
      drv(); rd_req = 1'b1; rd_req_addr = 24'h000040;
      wait_ev(1, 20, a);
      drv(); rd_req = 1'b0;
      drv();
      drv();
      #2 rst_n = 1'b0;
      #1 check("t6_async_outs", outs, '0);
      smp();
      rst_n = 1'b1;
      drv(); man_ready = 1'b1; b = n_resp;
      drv(); man_ready = 1'b0;
      repeat (6) smp();
      check("t6_no_resp", n_resp - b, 0);
      check("t6_err_cleared", timeout_err, 1'b0);
      check("t6_no_double_ack", n_dbl, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
